// File: rtl/exe_div_ctrl_pkg.sv
// Shared constants, FSM encoding and a sign helper for the iterative divider.
package exe_div_ctrl_pkg;

    localparam logic [6:0]  INST_TYPE_R_M = 7'b0110011;
    localparam logic [6:0]  FUNCT7_MULDIV = 7'b0000001;

    localparam logic [2:0]  INST_DIV  = 3'b100;
    localparam logic [2:0]  INST_DIVU = 3'b101;
    localparam logic [2:0]  INST_REM  = 3'b110;
    localparam logic [2:0]  INST_REMU = 3'b111;

    localparam logic [31:0] ZERO          = 32'h0000_0000;
    localparam logic        WRITE_ENABLE  = 1'b1;
    localparam logic        WRITE_DISABLE = 1'b0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } div_state_e;

    function automatic logic [31:0] abs32(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/exe_div_core.sv
// Restoring shift-subtract datapath: one quotient bit per step, MSB first.
module exe_div_core #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  load_i,
    input  logic                  step_i,
    input  logic [DATA_WIDTH-1:0] dividend_i,
    input  logic [DATA_WIDTH-1:0] divisor_i,
    output logic [DATA_WIDTH-1:0] quot_o,
    output logic [DATA_WIDTH-1:0] rem_o
);

    logic [DATA_WIDTH-1:0] rem_q, rem_d;
    logic [DATA_WIDTH-1:0] quot_q, quot_d;
    logic [DATA_WIDTH-1:0] dsr_q, dsr_d;
    logic [DATA_WIDTH:0]   shifted;
    logic [DATA_WIDTH:0]   diff;

    // quot_q starts as the dividend; its MSB feeds the remainder while quotient bits enter at the LSB
    always_comb begin
        shifted = {rem_q, quot_q[DATA_WIDTH-1]};
        diff    = shifted - {1'b0, dsr_q};
        rem_d   = rem_q;
        quot_d  = quot_q;
        dsr_d   = dsr_q;
        if (load_i) begin
            rem_d  = '0;
            quot_d = dividend_i;
            dsr_d  = divisor_i;
        end else if (step_i) begin
            if (!diff[DATA_WIDTH]) begin
                rem_d  = diff[DATA_WIDTH-1:0];
                quot_d = {quot_q[DATA_WIDTH-2:0], 1'b1};
            end else begin
                rem_d  = shifted[DATA_WIDTH-1:0];
                quot_d = {quot_q[DATA_WIDTH-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            rem_q  <= '0;
            quot_q <= '0;
            dsr_q  <= '0;
        end else begin
            rem_q  <= rem_d;
            quot_q <= quot_d;
            dsr_q  <= dsr_d;
        end
    end

    assign quot_o = quot_q;
    assign rem_o  = rem_q;

endmodule

// File: rtl/exe_div_ctrl.sv
// RV32M DIV/DIVU/REM/REMU controller: decode, sign handling, special cases and write-back.
module exe_div_ctrl
    import exe_div_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  valid_i,
    input  logic                  flush_i,
    input  logic [31:0]           inst_i,
    input  logic [DATA_WIDTH-1:0] op1_i,
    input  logic [DATA_WIDTH-1:0] op2_i,
    output logic                  stall_o,
    output logic [DATA_WIDTH-1:0] reg_wdata_o,
    output logic                  reg_we_o
);

    localparam int CNT_W = $clog2(DATA_WIDTH);

    div_state_e            state_q, state_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [1:0]            f3_q, f3_d;
    logic                  sign1_q, sign1_d;
    logic                  sign2_q, sign2_d;
    logic                  special_q, special_d;
    logic [DATA_WIDTH-1:0] spec_res_q, spec_res_d;

    logic [6:0]            opcode;
    logic [6:0]            funct7;
    logic [2:0]            funct3;
    logic                  start;
    logic                  is_signed_op;
    logic                  overflow;
    logic                  core_load;
    logic                  core_step;
    logic [DATA_WIDTH-1:0] core_quot;
    logic [DATA_WIDTH-1:0] core_rem;
    logic [DATA_WIDTH-1:0] result;
    logic                  unused_inst_bits;

    assign opcode = inst_i[6:0];
    assign funct3 = inst_i[14:12];
    assign funct7 = inst_i[31:25];
    assign unused_inst_bits = ^{inst_i[24:15], inst_i[11:7]};

    assign start        = valid_i && (opcode == INST_TYPE_R_M) && (funct7 == FUNCT7_MULDIV) && funct3[2];
    assign is_signed_op = !funct3[0];
    assign overflow     = is_signed_op && (op1_i == {1'b1, {(DATA_WIDTH-1){1'b0}}})
                          && (op2_i == {DATA_WIDTH{1'b1}});

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        f3_d       = f3_q;
        sign1_d    = sign1_q;
        sign2_d    = sign2_q;
        special_d  = special_q;
        spec_res_d = spec_res_q;
        stall_o    = 1'b0;
        core_load  = 1'b0;
        core_step  = 1'b0;
        if (flush_i) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        stall_o = 1'b1;
                        f3_d    = funct3[1:0];
                        if (op2_i == '0) begin
                            special_d  = 1'b1;
                            spec_res_d = funct3[1] ? op1_i : {DATA_WIDTH{1'b1}};
                            state_d    = S_DONE;
                        end else if (overflow) begin
                            special_d  = 1'b1;
                            spec_res_d = funct3[1] ? '0 : op1_i;
                            state_d    = S_DONE;
                        end else begin
                            special_d = 1'b0;
                            sign1_d   = is_signed_op && op1_i[DATA_WIDTH-1];
                            sign2_d   = is_signed_op && op2_i[DATA_WIDTH-1];
                            core_load = 1'b1;
                            count_d   = CNT_W'(DATA_WIDTH - 1);
                            state_d   = S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    stall_o   = 1'b1;
                    core_step = 1'b1;
                    if (count_q == '0) begin
                        state_d = S_DONE;
                    end else begin
                        count_d = count_q - 1'b1;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            f3_q       <= '0;
            sign1_q    <= 1'b0;
            sign2_q    <= 1'b0;
            special_q  <= 1'b0;
            spec_res_q <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            f3_q       <= f3_d;
            sign1_q    <= sign1_d;
            sign2_q    <= sign2_d;
            special_q  <= special_d;
            spec_res_q <= spec_res_d;
        end
    end

    exe_div_core #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_core (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .load_i     (core_load),
        .step_i     (core_step),
        .dividend_i (abs32(op1_i, is_signed_op)),
        .divisor_i  (abs32(op2_i, is_signed_op)),
        .quot_o     (core_quot),
        .rem_o      (core_rem)
    );

    // Magnitude result is corrected for sign only when leaving DONE; f3_q[1] selects remainder
    always_comb begin
        result = core_quot;
        if (special_q) begin
            result = spec_res_q;
        end else begin
            unique case (f3_q)
                2'b00:   result = (sign1_q ^ sign2_q) ? (~core_quot + 1'b1) : core_quot;
                2'b01:   result = core_quot;
                2'b10:   result = sign1_q ? (~core_rem + 1'b1) : core_rem;
                default: result = core_rem;
            endcase
        end
    end

    assign reg_we_o    = ((state_q == S_DONE) && !flush_i) ? WRITE_ENABLE : WRITE_DISABLE;
    assign reg_wdata_o = reg_we_o ? result : ZERO;

endmodule

// File: tb/tb_exe_div_ctrl.sv
// Randomised and directed checks of exe_div_ctrl against an arithmetic reference model.
module tb_exe_div_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        valid_i;
    logic        flush_i;
    logic [31:0] inst_i;
    logic [31:0] op1_i;
    logic [31:0] op2_i;
    logic        stall_o;
    logic [31:0] reg_wdata_o;
    logic        reg_we_o;

    int errors = 0;
    int checks = 0;

    exe_div_ctrl #(.DATA_WIDTH(32)) dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .valid_i     (valid_i),
        .flush_i     (flush_i),
        .inst_i      (inst_i),
        .op1_i       (op1_i),
        .op2_i       (op2_i),
        .stall_o     (stall_o),
        .reg_wdata_o (reg_wdata_o),
        .reg_we_o    (reg_we_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk_inst(input logic [6:0] f7, input logic [2:0] f3);
        logic [4:0] rs1, rs2, rd;
        rs1 = 5'($urandom);
        rs2 = 5'($urandom);
        rd  = 5'($urandom);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    // Reference: RISC-V M-extension semantics via 64-bit arithmetic
    function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        if (b == 32'd0) return f3[1] ? a : 32'hFFFF_FFFF;
        case (f3)
            3'b100:  return 32'(sa / sb);
            3'b101:  return 32'(ua / ub);
            3'b110:  return 32'(sa % sb);
            default: return 32'(ua % ub);
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0) return 1;
        if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // mode 0: run to completion; 1: flush in cycle k; 2: reset in cycle k (k < latency)
    task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input int mode, input int k);
        logic [31:0] exp_res;
        int          lat;
        exp_res = ref_result(f3, a, b);
        lat     = ref_latency(f3, a, b);
        @(posedge clk_i); #1;
        valid_i = 1'b1;
        flush_i = 1'b0;
        rst_n_i = 1'b1;
        inst_i  = mk_inst(7'b0000001, f3);
        op1_i   = a;
        op2_i   = b;
        for (int cyc = 0; cyc <= lat; cyc++) begin
            if (mode == 1 && cyc == k) flush_i = 1'b1;
            if (mode == 2 && cyc == k) rst_n_i = 1'b0;
            @(negedge clk_i);
            if (mode == 1 && cyc == k) begin
                chk("flush_stall", 32'(stall_o), 32'd0);
                chk("flush_we", 32'(reg_we_o), 32'd0);
                chk("flush_wdata", reg_wdata_o, 32'd0);
                $display("op f3=%b a=%h b=%h flushed at cycle %0d", f3, a, b, k);
                return;
            end
            chk("stall", 32'(stall_o), (cyc < lat) ? 32'd1 : 32'd0);
            chk("we", 32'(reg_we_o), (cyc == lat) ? 32'd1 : 32'd0);
            chk("wdata", reg_wdata_o, (cyc == lat) ? exp_res : 32'd0);
            if (mode == 2 && cyc == k) begin
                @(posedge clk_i); #1;
                rst_n_i = 1'b1;
                valid_i = 1'b0;
                @(negedge clk_i);
                chk("rst_stall", 32'(stall_o), 32'd0);
                chk("rst_we", 32'(reg_we_o), 32'd0);
                chk("rst_wdata", reg_wdata_o, 32'd0);
                $display("op f3=%b a=%h b=%h reset at cycle %0d", f3, a, b, k);
                return;
            end
            if (cyc < lat) begin
                @(posedge clk_i); #1;
            end
        end
        $display("op f3=%b a=%h b=%h result=%h expected=%h latency=%0d", f3, a, b, reg_wdata_o, exp_res, lat);
    endtask

    task automatic go_idle();
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        flush_i = 1'b0;
        @(negedge clk_i);
        chk("idle_stall", 32'(stall_o), 32'd0);
        chk("idle_we", 32'(reg_we_o), 32'd0);
    endtask

    task automatic non_div(input logic [6:0] f7, input logic [2:0] f3);
        @(posedge clk_i); #1;
        valid_i = 1'b1;
        inst_i  = mk_inst(f7, f3);
        op1_i   = $urandom;
        op2_i   = $urandom;
        repeat (3) begin
            @(negedge clk_i);
            chk("ignored_stall", 32'(stall_o), 32'd0);
            chk("ignored_we", 32'(reg_we_o), 32'd0);
            @(posedge clk_i); #1;
        end
        valid_i = 1'b0;
        $display("op f7=%b f3=%b ignored", f7, f3);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n_i = 1'b0;
        valid_i = 1'b0;
        flush_i = 1'b0;
        inst_i  = '0;
        op1_i   = '0;
        op2_i   = '0;
        repeat (3) @(posedge clk_i);
        #1;
        rst_n_i = 1'b1;
        @(negedge clk_i);
        chk("reset_stall", 32'(stall_o), 32'd0);
        chk("reset_we", 32'(reg_we_o), 32'd0);
        chk("reset_wdata", reg_wdata_o, 32'd0);

        do_op(3'b100, 32'd100, 32'd7, 0, 0);
        do_op(3'b110, 32'hFFFF_FF9C, 32'd7, 0, 0);
        do_op(3'b100, 32'hFFFF_FF9C, 32'd7, 0, 0);
        do_op(3'b101, 32'hFFFF_FFFF, 32'd1, 0, 0);
        do_op(3'b111, 32'hFFFF_FFFF, 32'h10, 0, 0);
        do_op(3'b100, 32'd5, 32'd0, 0, 0);
        do_op(3'b110, 32'd5, 32'd0, 0, 0);
        do_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
        do_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
        do_op(3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
        do_op(3'b100, 32'd1000, 32'd3, 1, 10);
        do_op(3'b100, 32'd9, 32'd3, 0, 0);
        do_op(3'b100, 32'd1000, 32'd3, 2, 5);
        do_op(3'b100, 32'd9, 32'd3, 0, 0);
        go_idle();
        non_div(7'b0000001, 3'b000);
        non_div(7'b0000000, 3'b100);

        for (int n = 0; n < 40; n++) begin
            logic [2:0]  f3;
            logic [31:0] a, b;
            int          mode;
            f3   = 3'($urandom_range(4, 7));
            a    = pick_operand();
            b    = pick_operand();
            mode = ($urandom_range(0, 7) == 0) ? 1 : 0;
            do_op(f3, a, b, mode, $urandom_range(0, ref_latency(f3, a, b)));
            if ($urandom_range(0, 3) == 0) go_idle();
        end
        go_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
